id_ex_stage: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded operands, register numbers, window bit and control from ID; presents them one cycle later to EX and to forwardUnit (readReg1_IDEX, readReg2_IDEX).
- Generates the stall that freezes PC and IF/ID, and injects bubbles on stall or flush.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths and the control bundle layout
package pipe_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 2;
    localparam int CTRL_W = 8;

    localparam int CTRL_REG_WRITE = 7;
    localparam int CTRL_MEM_READ  = 6;
    localparam int CTRL_MEM_WRITE = 5;
    localparam int CTRL_ALU_SRC   = 4;
    localparam int CTRL_ALU_OP_LO = 1;
    localparam int CTRL_BRANCH    = 0;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic [2:0] aluOp;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard check between ID/EX and ID
module load_use_detect #(
    parameter int REG_W = 2
) (
    input  logic             exValid,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exDest,
    input  logic             exWindow,
    input  logic             idValid,
    input  logic [REG_W-1:0] idReadReg1,
    input  logic [REG_W-1:0] idReadReg2,
    input  logic             idUsesR2,
    input  logic             idWindow,
    output logic             lu
);

    logic destMatch;

    // r0 never holds a loaded value, so a load into it can never be a producer
    assign destMatch = (exDest == idReadReg1) || (idUsesR2 && (exDest == idReadReg2));

    assign lu = exValid && exMemRead && (exDest != '0) && idValid
                && (exWindow == idWindow) && destMatch;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and stall counter
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_readReg1,
    input  logic [REG_W-1:0]  id_readReg2,
    input  logic              id_uses_r2,
    input  logic              id_window,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [7:0]        id_ctrl,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic [REG_W-1:0]  readReg1_IDEX,
    output logic [REG_W-1:0]  readReg2_IDEX,
    output logic              window_IDEX,
    output logic [DATA_W-1:0] data1_IDEX,
    output logic [DATA_W-1:0] data2_IDEX,
    output logic [DATA_W-1:0] imm_IDEX,
    output logic [7:0]        ctrl_IDEX,
    output logic              valid_IDEX,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    ctrl_t ctrlReg;
    logic  lu;
    logic  luStall;

    assign ctrl_IDEX = ctrlReg;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .exValid    (valid_IDEX),
        .exMemRead  (ctrl_IDEX[CTRL_MEM_READ]),
        .exDest     (readReg1_IDEX),
        .exWindow   (window_IDEX),
        .idValid    (id_valid),
        .idReadReg1 (id_readReg1),
        .idReadReg2 (id_readReg2),
        .idUsesR2   (id_uses_r2),
        .idWindow   (id_window),
        .lu         (lu)
    );

    // Only a load-use stall that actually inserts a bubble is counted
    assign luStall = lu && !ex_flush && !ex_hold;

    // Gated by rst so the reset cycle never freezes the front end on stale ID/EX state
    assign stall = !rst && (ex_hold || (lu && !ex_flush));

    always_ff @(posedge clk) begin
        if (rst) begin
            readReg1_IDEX <= '0;
            readReg2_IDEX <= '0;
            window_IDEX   <= 1'b0;
            data1_IDEX    <= '0;
            data2_IDEX    <= '0;
            imm_IDEX      <= '0;
            ctrlReg       <= CTRL_NOP;
            valid_IDEX    <= 1'b0;
        end else if (ex_flush || (lu && !ex_hold)) begin
            readReg1_IDEX <= '0;
            readReg2_IDEX <= '0;
            window_IDEX   <= 1'b0;
            data1_IDEX    <= '0;
            data2_IDEX    <= '0;
            imm_IDEX      <= '0;
            ctrlReg       <= CTRL_NOP;
            valid_IDEX    <= 1'b0;
        end else if (!ex_hold) begin
            readReg1_IDEX <= id_readReg1;
            readReg2_IDEX <= id_readReg2;
            window_IDEX   <= id_window;
            data1_IDEX    <= id_data1;
            data2_IDEX    <= id_data2;
            imm_IDEX      <= id_imm;
            ctrlReg       <= id_valid ? ctrl_t'(id_ctrl) : CTRL_NOP;
            valid_IDEX    <= id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (luStall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with directed vectors
module tb_id_ex_stage;

    localparam int DATA_W = 16;
    localparam int REG_W  = 2;
    localparam int CNT_W  = 4;
    localparam int VW     = 2*REG_W + 1 + 3*DATA_W + 8 + 1 + 1 + CNT_W;

    localparam logic [7:0] RW = 8'h80;
    localparam logic [7:0] LD = 8'hC0;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_W-1:0]  id_readReg1;
    logic [REG_W-1:0]  id_readReg2;
    logic              id_uses_r2;
    logic              id_window;
    logic [DATA_W-1:0] id_data1;
    logic [DATA_W-1:0] id_data2;
    logic [DATA_W-1:0] id_imm;
    logic [7:0]        id_ctrl;
    logic              ex_flush;
    logic              ex_hold;
    logic [REG_W-1:0]  readReg1_IDEX;
    logic [REG_W-1:0]  readReg2_IDEX;
    logic              window_IDEX;
    logic [DATA_W-1:0] data1_IDEX;
    logic [DATA_W-1:0] data2_IDEX;
    logic [DATA_W-1:0] imm_IDEX;
    logic [7:0]        ctrl_IDEX;
    logic              valid_IDEX;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    id_ex_stage #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_readReg1   (id_readReg1),
        .id_readReg2   (id_readReg2),
        .id_uses_r2    (id_uses_r2),
        .id_window     (id_window),
        .id_data1      (id_data1),
        .id_data2      (id_data2),
        .id_imm        (id_imm),
        .id_ctrl       (id_ctrl),
        .ex_flush      (ex_flush),
        .ex_hold       (ex_hold),
        .readReg1_IDEX (readReg1_IDEX),
        .readReg2_IDEX (readReg2_IDEX),
        .window_IDEX   (window_IDEX),
        .data1_IDEX    (data1_IDEX),
        .data2_IDEX    (data2_IDEX),
        .imm_IDEX      (imm_IDEX),
        .ctrl_IDEX     (ctrl_IDEX),
        .valid_IDEX    (valid_IDEX),
        .stall         (stall),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        string         name;
        logic [VW-1:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   nCmp  = 0;
    int   nBad  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] mk(
        input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2, input logic win,
        input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] imm,
        input logic [7:0] ctrl, input logic valid, input logic stl, input logic [CNT_W-1:0] cnt);
        return {r1, r2, win, d1, d2, imm, ctrl, valid, stl, cnt};
    endfunction

    wire [VW-1:0] obs = {readReg1_IDEX, readReg2_IDEX, window_IDEX, data1_IDEX, data2_IDEX,
                         imm_IDEX, ctrl_IDEX, valid_IDEX, stall, stall_cnt};

    // Monitor: compare every expectation due in the current cycle on the falling edge
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            nCmp++;
            if (e.cyc < cyc) begin
                nBad++;
                $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
            end else if (obs !== e.v) begin
                nBad++;
                $display("FAIL %s: got=%h required=%h", e.name, obs, e.v);
            end
        end
    end

    task automatic push(input string name, input logic [VW-1:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.v    = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2,
                         input logic u2, input logic w, input logic [DATA_W-1:0] d1,
                         input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] imm, input logic [7:0] c);
        id_valid    = v;
        id_readReg1 = r1;
        id_readReg2 = r2;
        id_uses_r2  = u2;
        id_window   = w;
        id_data1    = d1;
        id_data2    = d2;
        id_imm      = imm;
        id_ctrl     = c;
    endtask

    task automatic clrId();
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int wait_cnt;
        rst = 1'b1; ex_flush = 1'b0; ex_hold = 1'b0;
        setId(1, 1, 1, 1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, LD);
        step(); push("reset_state", mk(0,0,0,0,0,0,0,0,0,0));

        step(); rst = 1'b0;
        setId(1, 2, 3, 1, 0, 16'h1234, 16'h0055, 16'h0007, RW);
        push("pt_before", mk(0,0,0,0,0,0,0,0,0,0));
        step(); clrId();
        push("pass_through", mk(2,3,0,16'h1234,16'h0055,16'h0007,RW,1,0,0));

        step(); setId(1, 1, 0, 0, 0, 16'hAAAA, 0, 16'h0004, LD);
        push("invalid_capture", mk(0,0,0,0,0,0,0,0,0,0));
        step(); setId(1, 1, 2, 1, 0, 16'h1111, 16'h2222, 0, RW);
        push("lu_stall", mk(1,0,0,16'hAAAA,0,16'h0004,LD,1,1,0));
        step();
        push("lu_bubble", mk(0,0,0,0,0,0,0,0,0,1));
        step(); clrId();
        push("lu_capture", mk(1,2,0,16'h1111,16'h2222,0,RW,1,0,1));

        step(); setId(1, 0, 0, 0, 0, 0, 0, 0, LD);
        push("r0_setup", mk(0,0,0,0,0,0,0,0,0,1));
        step(); setId(1, 0, 0, 0, 0, 0, 0, 0, RW);
        push("r0_no_stall", mk(0,0,0,0,0,0,LD,1,0,1));
        step(); setId(1, 2, 0, 0, 1, 0, 0, 0, LD);
        push("win_setup", mk(0,0,0,0,0,0,RW,1,0,1));
        step(); setId(1, 2, 0, 0, 0, 0, 0, 0, RW);
        push("win_no_stall", mk(2,0,1,0,0,0,LD,1,0,1));
        step(); setId(1, 2, 0, 0, 0, 0, 0, 0, LD);
        push("r2_setup", mk(2,0,0,0,0,0,RW,1,0,1));
        step(); setId(1, 3, 2, 0, 0, 0, 0, 0, RW);
        push("r2_unused_no_stall", mk(2,0,0,0,0,0,LD,1,0,1));

        step(); setId(1, 3, 0, 0, 0, 0, 0, 0, LD);
        push("flush_setup", mk(3,2,0,0,0,0,RW,1,0,1));
        step(); setId(1, 3, 0, 0, 0, 0, 0, 0, RW); ex_flush = 1'b1;
        push("flush_no_stall", mk(3,0,0,0,0,0,LD,1,0,1));
        step(); ex_flush = 1'b0; clrId();
        push("flush_bubble", mk(0,0,0,0,0,0,0,0,0,1));

        step(); setId(1, 1, 2, 1, 1, 16'h0A0A, 16'h0B0B, 16'h000C, 8'h12);
        push("hold_setup", mk(0,0,0,0,0,0,0,0,0,1));
        step(); ex_hold = 1'b1; setId(1, 2, 3, 1, 0, 16'h0005, 16'h0006, 16'h0007, RW);
        push("hold1", mk(1,2,1,16'h0A0A,16'h0B0B,16'h000C,8'h12,1,1,1));
        step(); setId(1, 3, 1, 0, 1, 16'h0008, 16'h0009, 16'h000A, LD);
        push("hold2", mk(1,2,1,16'h0A0A,16'h0B0B,16'h000C,8'h12,1,1,1));
        step(); setId(1, 0, 0, 0, 0, 16'h000F, 16'h000E, 16'h000D, 8'h01);
        push("hold3", mk(1,2,1,16'h0A0A,16'h0B0B,16'h000C,8'h12,1,1,1));
        step(); ex_hold = 1'b0;
        push("hold_release", mk(1,2,1,16'h0A0A,16'h0B0B,16'h000C,8'h12,1,0,1));
        step(); clrId();
        push("hold_resume", mk(0,0,0,16'h000F,16'h000E,16'h000D,8'h01,1,0,1));

        step(); setId(1, 1, 0, 0, 0, 16'h0077, 0, 0, LD);
        push("rst_setup", mk(0,0,0,0,0,0,0,0,0,1));
        step(); setId(1, 1, 0, 0, 0, 0, 0, 0, RW);
        push("pre_reset_stall", mk(1,0,0,16'h0077,0,0,LD,1,1,1));
        @(negedge clk); #1 rst = 1'b1;
        step();
        push("reset_mid_stall", mk(0,0,0,0,0,0,0,0,0,0));
        step(); rst = 1'b0;
        push("no_stale_stall", mk(0,0,0,0,0,0,0,0,0,0));

        step(); setId(1, 1, 0, 0, 0, 0, 0, 0, LD);
        push("sat_setup", mk(1,0,0,0,0,0,RW,1,0,0));
        for (int i = 0; i < 42; i++) begin
            int j;
            logic [CNT_W-1:0] c;
            step();
            j = i / 2;
            if (i % 2 == 0) begin
                c = (j > 15) ? 4'd15 : CNT_W'(j);
                push($sformatf("sat_stall_%0d", i), mk(1,0,0,0,0,0,LD,1,1,c));
            end else begin
                c = (j + 1 > 15) ? 4'd15 : CNT_W'(j + 1);
                push($sformatf("sat_bubble_%0d", i), mk(0,0,0,0,0,0,0,0,0,c));
            end
        end

        step(); clrId();
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 20) begin
            step();
            wait_cnt++;
        end
        if (q.size() > 0) begin
            nCmp++;
            nBad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
